ldst_arbiter: RTL
=================

# ldst_arbiter

Shares the single load/store port (start/ready handshake, `ptr` address, `word` data) among `N_REQ` requesters, e.g. the core's load/store unit and a DMA/debug master. Sits upstream of the L1d/IO address-decode switch and presents exactly one outstanding transaction to it at a time. Each requester's start pulse is latched into a pending slot, arbitrated round-robin (or fixed priority), issued downstream, and completed with a ready pulse routed back to the owner.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, at least 2.
- `ROUND_ROBIN`, default 1: 1 selects round-robin; 0 selects fixed priority, lowest index wins.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_start[N_REQ]`, in, 1 each: one-cycle command pulse per requester.
- `req_write[N_REQ]`, in, 1 each: write when 1; sampled with `req_start`.
- `req_addr[N_REQ]`, in, `ptr` each: word address; sampled with `req_start`.
- `req_data_wr[N_REQ]`, in, `word` each: write data; sampled with `req_start`.
- `req_ready`, out, `N_REQ`: one-hot completion pulse to the owning requester.
- `req_data_rd`, out, `word`: read data, broadcast; valid only with the matching `req_ready` bit.
- `mem_start`, out, 1: downstream start pulse.
- `mem_write`, out, 1: downstream write flag.
- `mem_addr`, out, `ptr`: downstream address.
- `mem_data_wr`, out, `word`: downstream write data.
- `mem_ready`, in, 1: downstream completion pulse.
- `mem_data_rd`, in, `word`: downstream read data.
- `busy`, out, 1: a transaction is outstanding downstream.
- `grant`, out, `$clog2(N_REQ)`: index of the current or last owner.
- `err_overlap`, out, 1: sticky protocol-violation flag.

## Operation
Pending slots:
- One slot per requester: valid bit, write, addr, data_wr.
- `req_start[i]` with slot i empty loads the slot; the valid bit is set the next cycle.
- `req_start[i]` with slot i already valid is a protocol violation. The command is dropped, the slot keeps its original contents, and `err_overlap` is set until reset.

FSM `ldst_arb_state`, reset value IDLE:
- IDLE: if any slot is valid, pick a winner `w`. Drive `mem_start=1` with slot `w` fields combinationally, register `grant<=w`, go to WAIT. `mem_ready` is ignored in IDLE.
- WAIT: `mem_*` fields stay driven from slot `grant`; `mem_start=0`. On `mem_ready`:
  - `req_ready[grant]=1` and `req_data_rd=mem_data_rd` in the same cycle (combinational pass-through).
  - Slot `grant` is cleared.
  - The round-robin pointer is updated to `grant`.
  - The FSM returns to IDLE.

Arbitration:
- Round-robin: search starts at pointer+1 modulo `N_REQ` and wraps.
- Fixed priority: lowest valid index wins.
- Only registered valid bits take part. A start arriving in the current cycle is not eligible that cycle.

Simultaneous events:
- `req_start[grant]` in the same cycle as `mem_ready` for that grant is legal. The clear and the new load resolve to a loaded slot, and no error is flagged.

Reset values:
- All slots empty, pointer = `N_REQ-1` (so requester 0 is first), `grant=0`.
- `busy=0`, `err_overlap=0`, `mem_start=0`, `req_ready=0`.
- `mem_*` data outputs and `req_data_rd` are 0 while IDLE with no slot valid.

Reset mid-transaction:
- Everything clears immediately and the outstanding downstream access is abandoned. The downstream switch shares `rst_n`, so no stray `mem_ready` can follow.

## Timing
- Latency: `req_start` at cycle t gives `mem_start` at t+1 at the earliest (arbiter idle, requester wins).
- Completion: `mem_ready` at cycle u gives `req_ready` at u, 0 cycles added. The next `mem_start` can be at u+1.
- `busy` is 1 exactly while in WAIT.
- `mem_start` is high for exactly one cycle per transaction.
- Downstream is required to return `mem_ready` no earlier than the cycle after `mem_start`.
- Throughput: one transaction per (downstream latency + 1) cycles.
- Requesters issue at most one outstanding command each.

## Structure
- `ptr` and `word` are already defined in `types.sv`.
- Add the `ldst_arb_state` enum (IDLE, WAIT) to `types.sv`.
- Sub-module `ldst_rr_pick`: purely combinational. Inputs are the valid vector, pointer and mode; outputs are `any` and the winner index. Reusable for other arbiters.

## Test plan
- Single read: requester 0 start at t, addr 0x0000_0010. `mem_start` at t+1 with that addr. `mem_ready` at t+3 with data 0xDEAD_BEEF gives `req_ready=2'b01` and `req_data_rd=0xDEAD_BEEF` at t+3, and `busy` falls at t+4.
- Simultaneous starts, round-robin: both at t after reset. Requester 0 is issued at t+1. After its ready at u, requester 1's `mem_start` is at u+1. Repeating the pair gives order 0,1,0,1.
- Fixed priority (`ROUND_ROBIN=0`): requester 0 restarts every time it is completed, requester 1 pending. Requester 1 is never granted while 0 stays pending.
- Back-to-back: requester 1 reissues start in the same cycle as its `req_ready`. The command is issued at the next idle opportunity and `err_overlap` stays 0.
- Overlap: requester 0 starts twice before ready, second with addr 0x100. The second command is dropped, `mem_addr` keeps the first address, and `err_overlap=1` sticky.
- Reset mid-op: assert `rst_n=0` during WAIT. All outputs immediately take their reset values, and a fresh request after release completes normally.

Source files
------------

// File: rtl/ldst_arbiter_pkg.sv
// Shared load/store port types and the arbiter FSM state encoding.
package ldst_arbiter_pkg;
    localparam int PTR_W  = 32;
    localparam int WORD_W = 32;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [WORD_W-1:0] word;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ldst_arb_state;
endpackage

// File: rtl/ldst_rr_pick.sv
// Combinational winner select: round-robin after a pointer, or lowest-index priority.
module ldst_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vld,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             round_robin,
    output logic             any,
    output logic [IDX_W-1:0] win
);
    int idx;

    always_comb begin
        win = '0;
        idx = 0;
        any = |vld;
        if (round_robin) begin
            // Walk from the farthest candidate back so the nearest one after rr_ptr wins.
            for (int k = N; k >= 1; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                if (vld[idx[IDX_W-1:0]]) win = idx[IDX_W-1:0];
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vld[i[IDX_W-1:0]]) win = i[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/ldst_arbiter.sv
// Arbitrates N_REQ requesters onto one load/store port, one outstanding access at a time.
module ldst_arbiter
    import ldst_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_start,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [PTR_W-1:0]           req_addr    [N_REQ],
    input  logic [WORD_W-1:0]          req_data_wr [N_REQ],
    output logic [N_REQ-1:0]           req_ready,
    output logic [WORD_W-1:0]          req_data_rd,
    output logic                       mem_start,
    output logic                       mem_write,
    output logic [PTR_W-1:0]           mem_addr,
    output logic [WORD_W-1:0]          mem_data_wr,
    input  logic                       mem_ready,
    input  logic [WORD_W-1:0]          mem_data_rd,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant,
    output logic                       err_overlap
);
    localparam int IDX_W = $clog2(N_REQ);

    ldst_arb_state    state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sel;
    logic             any;
    logic             done;
    logic             drive;
    logic             overlap;
    logic [N_REQ-1:0] slot_vld;
    logic [N_REQ-1:0] slot_write;
    ptr               slot_addr [N_REQ];
    word              slot_data [N_REQ];
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] load;

    ldst_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .vld         (slot_vld),
        .rr_ptr      (rr_ptr),
        .round_robin (ROUND_ROBIN != 0),
        .any         (any),
        .win         (win)
    );

    // A slot being completed this cycle may be reloaded by its owner without error.
    always_comb begin
        done    = (state == WAIT) && mem_ready;
        overlap = 1'b0;
        clr     = '0;
        load    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr[i]  = done && (grant == IDX_W'(i));
            load[i] = req_start[i] && (!slot_vld[i] || clr[i]);
            if (req_start[i] && slot_vld[i] && !clr[i]) overlap = 1'b1;
        end
    end

    always_comb begin
        sel         = (state == IDLE) ? win : grant;
        drive       = (state == WAIT) || any;
        mem_start   = (state == IDLE) && any;
        busy        = (state == WAIT);
        mem_write   = drive && slot_write[sel];
        mem_addr    = drive ? slot_addr[sel] : '0;
        mem_data_wr = drive ? slot_data[sel] : '0;
        req_ready   = clr;
        req_data_rd = done ? mem_data_rd : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= IDX_W'(N_REQ - 1);
            slot_vld    <= '0;
            err_overlap <= 1'b0;
        end else begin
            slot_vld <= (slot_vld & ~clr) | load;
            if (overlap) err_overlap <= 1'b1;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant <= win;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is qualified by slot_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (load[i]) begin
                slot_write[i] <= req_write[i];
                slot_addr[i]  <= req_addr[i];
                slot_data[i]  <= req_data_wr[i];
            end
        end
    end
endmodule
